instruction_fetch: RTL

Instruction fetch unit that drives the program counter load port of the register file and reads its program counter output. It issues one instruction-memory request per instruction, presents the fetched word to decode over a valid/ready handshake, and advances the PC by `pc_step` after each successful fetch. Redirects (branch, jump, trap) reload the PC and discard in-flight work.

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM driving the register-file PC load port and a valid/ready decode handoff.
// Define FETCH_ALIGN_CHECK_EN to fault on redirects whose target is not word-aligned.
module instruction_fetch #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] reset_vector = '0,
    parameter logic [WORD_SIZE-1:0] pc_step      = WORD_SIZE'(4)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_pc,
    output logic                 o_load_pc,
    output logic [WORD_SIZE-1:0] o_load_pc_data,
    output logic                 o_mem_req,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    input  logic                 i_mem_ack,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    input  logic                 i_mem_err,
    output logic                 o_instr_valid,
    output logic [WORD_SIZE-1:0] o_instr,
    output logic [WORD_SIZE-1:0] o_instr_pc,
    input  logic                 i_instr_ready,
    input  logic                 i_redirect,
    input  logic [WORD_SIZE-1:0] i_redirect_target,
    output logic                 o_fetch_fault,
    output logic                 o_fetch_misaligned
);
    typedef enum logic [2:0] {BOOT, PCWAIT, FETCH, HOLD, FAULT} state_t;
    state_t                r_state, w_state_nx;
    logic                  r_load_pc, w_load_pc_nx;
    logic [WORD_SIZE-1:0]  r_load_pc_data, w_load_pc_data_nx;
    logic                  r_instr_valid, w_instr_valid_nx;
    logic [WORD_SIZE-1:0]  r_instr, w_instr_nx;
    logic [WORD_SIZE-1:0]  r_instr_pc, w_instr_pc_nx;
    logic                  r_fault, w_fault_nx;
    logic                  r_misaligned, w_misaligned_nx;
    logic                  w_bad_target;
    logic                  w_ack;
`ifdef FETCH_ALIGN_CHECK_EN
    assign w_bad_target = |i_redirect_target[1:0];
`else
    assign w_bad_target = 1'b0;
`endif
    // An ack only counts while a request is actually outstanding
    assign w_ack = (r_state == FETCH) && i_mem_ack;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= BOOT;
            r_load_pc      <= 1'b0;
            r_load_pc_data <= '0;
            r_instr_valid  <= 1'b0;
            r_instr        <= '0;
            r_instr_pc     <= '0;
            r_fault        <= 1'b0;
            r_misaligned   <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_load_pc      <= w_load_pc_nx;
            r_load_pc_data <= w_load_pc_data_nx;
            r_instr_valid  <= w_instr_valid_nx;
            r_instr        <= w_instr_nx;
            r_instr_pc     <= w_instr_pc_nx;
            r_fault        <= w_fault_nx;
            r_misaligned   <= w_misaligned_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        if (r_state == BOOT)
            w_state_nx = PCWAIT;
        else if (i_redirect)
            w_state_nx = w_bad_target ? FAULT : PCWAIT;
        else if (r_state == PCWAIT)
            w_state_nx = FETCH;
        else if (w_ack)
            w_state_nx = i_mem_err ? FAULT : HOLD;
        else if (r_state == HOLD && i_instr_ready)
            w_state_nx = FETCH;
    end
    always_comb begin
        w_load_pc_nx      = 1'b0;
        w_load_pc_data_nx = r_load_pc_data;
        w_instr_valid_nx  = r_instr_valid;
        w_instr_nx        = r_instr;
        w_instr_pc_nx     = r_instr_pc;
        w_fault_nx        = r_fault;
        w_misaligned_nx   = r_misaligned;
        if (r_state == BOOT) begin
            w_load_pc_nx      = 1'b1;
            w_load_pc_data_nx = reset_vector;
        end else if (i_redirect) begin
            w_instr_valid_nx  = 1'b0;
            w_fault_nx        = 1'b0;
            w_misaligned_nx   = w_bad_target;
            w_load_pc_nx      = !w_bad_target;
            w_load_pc_data_nx = w_bad_target ? r_load_pc_data : i_redirect_target;
        end else if (w_ack && i_mem_err) begin
            w_fault_nx = 1'b1;
        end else if (w_ack) begin
            w_instr_valid_nx  = 1'b1;
            w_instr_nx        = i_mem_rdata;
            w_instr_pc_nx     = i_pc;
            w_load_pc_nx      = 1'b1;
            w_load_pc_data_nx = i_pc + pc_step;
        end else if (r_state == HOLD && i_instr_ready) begin
            w_instr_valid_nx = 1'b0;
        end
    end
    assign o_mem_req          = (r_state == FETCH);
    assign o_mem_addr         = i_pc;
    assign o_load_pc          = r_load_pc;
    assign o_load_pc_data     = r_load_pc_data;
    assign o_instr_valid      = r_instr_valid;
    assign o_instr            = r_instr;
    assign o_instr_pc         = r_instr_pc;
    assign o_fetch_fault      = r_fault;
    assign o_fetch_misaligned = r_misaligned;
endmodule
